// File: rtl/riscv_fetch_unit.sv
// ---------------------------------------------------------------------------
// riscv_fetch_unit
//
// Instruction fetch front end: issues sequential word fetches to instruction
// memory, buffers in-order responses in a small FIFO together with their PC,
// and presents the FIFO head to decode. A redirect flushes the FIFO, restarts
// fetch at the target and discards every response still in flight.
//
// Parameters
//   P_DEPTH     FIFO entries (power of two, >= 2)
//   P_RESET_PC  first fetch address after reset
//
// Ports
//   i_clk, i_rstn                  clock, asynchronous active-low reset
//   i_redirect, i_redirect_pc      one-cycle redirect pulse and its target
//   o_imem_req, o_imem_addr        fetch request / address
//   i_imem_ready                   memory accepts the request this cycle
//   i_imem_rvalid, i_imem_rdata    in-order response, >= 1 cycle after accept
//   o_valid_d, o_instr_d, o_pc_d,
//   o_pc_plus_4_d, i_ready_d       FIFO head toward decode (pop on valid&ready)
//   o_misalign                     sticky misaligned-redirect flag
//
// Optional feature
//   FETCH_MISALIGN_CHK_EN  when defined, a redirect target with non-zero
//   low bits sets o_misalign and stalls fetch until an aligned redirect;
//   when undefined the low target bits are forced to zero and o_misalign=0.
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module riscv_fetch_unit #(
    parameter int              P_DEPTH    = 4,
    parameter logic [`XLEN-1:0] P_RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_redirect,
    input  logic [`XLEN-1:0]  i_redirect_pc,
    output logic              o_imem_req,
    output logic [`XLEN-1:0]  o_imem_addr,
    input  logic              i_imem_ready,
    input  logic              i_imem_rvalid,
    input  logic [`XLEN-1:0]  i_imem_rdata,
    output logic              o_valid_d,
    output logic [`XLEN-1:0]  o_instr_d,
    output logic [`XLEN-1:0]  o_pc_d,
    output logic [`XLEN-1:0]  o_pc_plus_4_d,
    input  logic              i_ready_d,
    output logic              o_misalign
);

    localparam int XLEN = `XLEN;
    localparam int AW   = $clog2(P_DEPTH);
    localparam int CW   = AW + 1;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] resp_pc_q;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_nxt;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   count;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW:0]     inflight;

    logic [XLEN-1:0] fifo_instr [P_DEPTH];
    logic [XLEN-1:0] fifo_pc    [P_DEPTH];

    logic [XLEN-1:0] target;
    logic            misalign_q;
    logic            accept;
    logic            push;
    logic            pop;
    logic            dropping;

    // Redirect target and misalignment tracking
`ifdef FETCH_MISALIGN_CHK_EN
    assign target = i_redirect_pc;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            misalign_q <= 1'b0;
        end else if (i_redirect) begin
            misalign_q <= |i_redirect_pc[1:0];
        end
    end
`else
    assign target     = i_redirect_pc & ~XLEN'(3);
    assign misalign_q = 1'b0;
`endif

    assign o_misalign = misalign_q;

    // Entries already buffered plus those still in flight bound the FIFO
    // occupancy, so gating requests on their sum rules out overflow.
    assign inflight   = {1'b0, count} + {1'b0, outstanding};
    assign o_imem_req = i_rstn & ~i_redirect & ~misalign_q &
                        (inflight < (CW+1)'(P_DEPTH));
    assign o_imem_addr = pc_q;
    assign accept      = o_imem_req & i_imem_ready;

    // Responses are discarded on a redirect cycle and while stale ones remain.
    assign dropping = (drop_cnt != '0);
    assign push     = i_imem_rvalid & ~i_redirect & ~dropping;

    assign o_valid_d     = (count != '0) & ~i_redirect;
    assign pop           = o_valid_d & i_ready_d;
    assign o_instr_d     = fifo_instr[rd_ptr];
    assign o_pc_d        = fifo_pc[rd_ptr];
    assign o_pc_plus_4_d = o_pc_d + XLEN'(4);

    always_comb begin
        outstanding_nxt = outstanding;
        case ({accept, i_imem_rvalid})
            2'b10:   outstanding_nxt = outstanding + CW'(1);
            2'b01:   outstanding_nxt = outstanding - CW'(1);
            default: outstanding_nxt = outstanding;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pc_q        <= P_RESET_PC;
            resp_pc_q   <= P_RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (i_redirect) begin
                pc_q      <= target;
                resp_pc_q <= target;
                // A response arriving in the redirect cycle is itself dropped
                // here, so it is not counted again.
                drop_cnt  <= outstanding - CW'(i_imem_rvalid);
                count     <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
            end else begin
                if (accept) begin
                    pc_q <= pc_q + XLEN'(4);
                end
                if (i_imem_rvalid && dropping) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push) begin
                    resp_pc_q <= resp_pc_q + XLEN'(4);
                    wr_ptr    <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // FIFO storage needs no reset: occupancy is tracked by count.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= i_imem_rdata;
            fifo_pc[wr_ptr]    <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_riscv_fetch_unit
//
// Directed bench for riscv_fetch_unit (P_DEPTH=4, P_RESET_PC=0). A small
// in-order memory model answers each accepted request one cycle later with
// data = address ^ 32'hDEAD_0000, and can be paused to build up requests.
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module tb_riscv_fetch_unit;

    logic        clk;
    logic        rstn;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus_4_d;
    logic        ready_d;
    logic        misalign;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned n_fail  = 0;
    int unsigned n_acc   = 0;
    logic        rsp_en;
    logic [31:0] mq[$];

    riscv_fetch_unit #(
        .P_DEPTH    (4),
        .P_RESET_PC (32'h0000_0000)
    ) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_ready  (imem_ready),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .o_valid_d     (valid_d),
        .o_instr_d     (instr_d),
        .o_pc_d        (pc_d),
        .o_pc_plus_4_d (pc_plus_4_d),
        .i_ready_d     (ready_d),
        .o_misalign    (misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: record the accept seen before the edge, then present the
    // next in-order response (if enabled) for the following edge.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = imem_req && imem_ready;
        a   = imem_addr;
        @(posedge clk);
        #1;
        if (acc) begin
            mq.push_back(a);
            n_acc++;
        end
        if (rsp_en && mq.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data(mq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
    endtask

    task automatic wait_valid(input int unsigned max_cycles, output logic ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < max_cycles; i++) begin
            if (valid_d) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (valid_d) ok = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect    = 1'b1;
        redirect_pc = t;
        tick();
        redirect    = 1'b0;
        #1;
    endtask

    logic ok;

    initial begin
        rstn        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        ready_d     = 1'b0;
        rsp_en      = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_req",      {31'd0, imem_req},  32'd0);
        chk("rst_valid",    {31'd0, valid_d},   32'd0);
        chk("rst_misalign", {31'd0, misalign},  32'd0);
        chk("rst_addr",     imem_addr,          32'h0);

        // Release: first request in the very next cycle
        rstn = 1'b1;
        #1;
        chk("rel_req",  {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr,         32'h0);

        // Sequential fetch and 2-cycle latency, decode stalled
        tick();
        chk("seq_addr1", imem_addr, 32'h4);
        tick();
        chk("lat_valid", {31'd0, valid_d}, 32'd1);
        chk("lat_pc",    pc_d,             32'h0);
        chk("lat_pc4",   pc_plus_4_d,      32'h4);
        chk("lat_instr", instr_d,          32'hDEAD_0000);
        chk("seq_addr2", imem_addr,        32'h8);
        tick();
        chk("seq_addr3", imem_addr,        32'hC);
        chk("seq_req3",  {31'd0, imem_req}, 32'd1);
        tick();
        chk("full_req_a", {31'd0, imem_req}, 32'd0);
        tick();
        chk("full_req_b", {31'd0, imem_req}, 32'd0);
        chk("full_nacc",  n_acc,             32'd4);
        chk("full_head",  pc_d,              32'h0);

        // One pop re-enables exactly one request
        ready_d = 1'b1;
        tick();
        ready_d = 1'b0;
        chk("pop_head", pc_d,              32'h4);
        chk("pop_req",  {31'd0, imem_req}, 32'd1);
        chk("pop_addr", imem_addr,         32'h10);
        tick();
        chk("pop_req_after", {31'd0, imem_req}, 32'd0);
        chk("pop_nacc",      n_acc,             32'd5);
        tick();

        // Redirect with a full buffer: head hidden in the redirect cycle
        rsp_en      = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        #1;
        chk("rdr_valid_forced", {31'd0, valid_d}, 32'd0);
        chk("rdr_req_forced",   {31'd0, imem_req}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("flush_valid", {31'd0, valid_d}, 32'd0);
        chk("flush_addr",  imem_addr,        32'h80);

        // Three outstanding, then redirect to 0x100
        tick();
        tick();
        tick();
        chk("out3_addr", imem_addr,         32'h8C);
        chk("out3_req",  {31'd0, imem_req}, 32'd1);
        do_redirect(32'h100);
        rsp_en = 1'b1;
        chk("r100_addr", imem_addr, 32'h100);
        wait_valid(20, ok);
        chk("r100_timeout", {31'd0, ok}, 32'd1);
        chk("r100_pc",      pc_d,        32'h100);
        chk("r100_instr",   instr_d,     32'hDEAD_0100);

        // Drain everything in flight
        imem_ready = 1'b0;
        for (int unsigned i = 0; i < 12; i++) begin
            if (mq.size() == 0 && !imem_rvalid) break;
            tick();
        end
        tick();

        // Redirect while two stale responses are still to be dropped
        rsp_en     = 1'b0;
        imem_ready = 1'b1;
        do_redirect(32'h180);
        tick();
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h190;
        tick();
        redirect   = 1'b0;
        imem_ready = 1'b0;
        rsp_en     = 1'b1;
        tick();
        rsp_en = 1'b0;
        tick();
        do_redirect(32'h200);
        imem_ready = 1'b1;
        rsp_en     = 1'b1;
        ready_d    = 1'b1;
        chk("r200_addr", imem_addr, 32'h200);
        wait_valid(20, ok);
        chk("r200_timeout", {31'd0, ok}, 32'd1);
        chk("r200_pc",      pc_d,        32'h200);
        chk("r200_instr",   instr_d,     32'hDEAD_0200);

        // Address wrap at the top of the address space
        ready_d = 1'b0;
        do_redirect(32'hFFFF_FFFC);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr1", imem_addr, 32'h0000_0000);
        wait_valid(20, ok);
        chk("wrap_timeout", {31'd0, ok}, 32'd1);
        chk("wrap_pc",      pc_d,        32'hFFFF_FFFC);
        chk("wrap_pc4",     pc_plus_4_d, 32'h0000_0000);
        chk("wrap_instr",   instr_d,     32'h2152_FFFC);

        // Misaligned redirect
        do_redirect(32'h102);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_set",   {31'd0, misalign}, 32'd1);
        chk("mis_req",   {31'd0, imem_req}, 32'd0);
        tick();
        tick();
        chk("mis_hold",  {31'd0, misalign}, 32'd1);
        chk("mis_req2",  {31'd0, imem_req}, 32'd0);
        do_redirect(32'h104);
        chk("mis_clear", {31'd0, misalign}, 32'd0);
        chk("mis_addr",  imem_addr,         32'h104);
        wait_valid(20, ok);
        chk("mis_timeout", {31'd0, ok}, 32'd1);
        chk("mis_pc",      pc_d,        32'h104);
        chk("mis_instr",   instr_d,     32'hDEAD_0104);
`else
        chk("mis_tied", {31'd0, misalign}, 32'd0);
        chk("mis_addr", imem_addr,         32'h100);
        wait_valid(20, ok);
        chk("mis_timeout", {31'd0, ok}, 32'd1);
        chk("mis_pc",      pc_d,        32'h100);
        chk("mis_instr",   instr_d,     32'hDEAD_0100);
`endif

        // Reset mid-operation abandons everything in flight
        tick();
        rstn = 1'b0;
        mq.delete();
        imem_rvalid = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, valid_d},  32'd0);
        chk("mrst_req",   {31'd0, imem_req}, 32'd0);
        chk("mrst_addr",  imem_addr,         32'h0);
        tick();
        tick();
        rstn = 1'b1;
        #1;
        chk("mrel_req",  {31'd0, imem_req}, 32'd1);
        chk("mrel_addr", imem_addr,         32'h0);
        wait_valid(10, ok);
        chk("mrel_timeout", {31'd0, ok}, 32'd1);
        chk("mrel_pc",      pc_d,        32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_unit.md
RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

Interface
REQ-001 P_DEPTH, default 4: instruction-buffer entries. SHALL be a power of two, minimum 2.
REQ-002 P_RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 i_clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 i_rstn  in  1  reset, asynchronous, active-low.
REQ-005 i_redirect  in  1  SHALL be asserted for one cycle per redirect event; flushes the unit and restarts fetch.
REQ-006 i_redirect_pc  in  `XLEN  redirect target, sampled when i_redirect=1.
REQ-007 o_imem_req  out  1  request valid; a request is accepted when o_imem_req & i_imem_ready.
REQ-008 o_imem_addr  out  `XLEN  request address.
REQ-009 i_imem_ready  in  1  memory accepts the request this cycle.
REQ-010 i_imem_rvalid  in  1  response valid; responses SHALL be in order and arrive 1 or more cycles after acceptance.
REQ-011 i_imem_rdata  in  `XLEN  response instruction word.
REQ-012 o_valid_d  out  1  buffer head valid toward decode.
REQ-013 o_instr_d  out  `XLEN  head instruction.
REQ-014 o_pc_d  out  `XLEN  head PC.
REQ-015 o_pc_plus_4_d  out  `XLEN  o_pc_d+4, modulo 2^XLEN.
REQ-016 i_ready_d  in  1  decode accepts the head; pop when o_valid_d & i_ready_d.
REQ-017 o_misalign  out  1  misaligned-redirect flag (see Configuration).

Function
REQ-018 Fetch-PC register pc_q SHALL drive o_imem_addr; on each accepted request it SHALL advance by 4, wrapping modulo 2^XLEN.
REQ-019 o_imem_req SHALL be 1 iff !i_redirect and (count + outstanding) < P_DEPTH, so the buffer can never overflow.
REQ-020 Outstanding counter: +1 on accept, -1 on i_imem_rvalid, unchanged when both occur in the same cycle. Width: clog2(P_DEPTH)+1.
REQ-021 Response-PC register resp_pc_q holds the address of the oldest outstanding request; it SHALL advance by 4 per buffered response.
REQ-022 A non-dropped response SHALL write {resp_pc_q, i_imem_rdata} into the buffer tail; it becomes visible on o_valid_d the next cycle.
REQ-023 Minimum latency from acceptance to o_valid_d: 2 cycles (1 memory cycle, 1 buffer cycle).
REQ-024 Push and pop in the same cycle SHALL leave count unchanged, including at full and at count=1.
REQ-025 Buffer pointers SHALL wrap modulo P_DEPTH. Empty: o_valid_d=0 and o_instr_d/o_pc_d are don't-care.
REQ-026 Redirect cycle behaviour:
- o_valid_d forced to 0, so no pop occurs.
- Buffer flushed.
- pc_q and resp_pc_q both loaded with the target.
- drop_cnt loaded with outstanding minus any response arriving this cycle; that response is discarded.
REQ-027 While drop_cnt != 0, each response SHALL be discarded and decrement both drop_cnt and outstanding.
REQ-028 New requests MAY issue from the cycle after a redirect, while drops are still pending.
REQ-029 A redirect while drop_cnt != 0 SHALL reload drop_cnt with the full outstanding count.

Reset
REQ-030 While i_rstn=0:
- pc_q=P_RESET_PC; outstanding, drop_cnt, count, pointers=0.
- o_valid_d=0, o_imem_req=0, o_misalign=0.
REQ-031 The first request SHALL be driven in the first clock cycle after i_rstn deasserts. Reset mid-operation SHALL abandon all in-flight responses.

Configuration
REQ-032 Macro FETCH_MISALIGN_CHK_EN defined:
- A redirect with i_redirect_pc[1:0] != 0 SHALL set o_misalign.
- o_misalign is sticky and holds o_imem_req=0 until an aligned redirect clears it.
- The buffer is still flushed by that redirect.
REQ-033 Macro FETCH_MISALIGN_CHK_EN undefined: i_redirect_pc[1:0] SHALL be treated as 2'b00, and o_misalign SHALL be tied to 0.

Verification
REQ-034 Reset release, i_imem_ready=1, 1-cycle response, i_ready_d=1 -> addresses 0x0, 0x4, 0x8 on consecutive cycles; first o_valid_d 2 cycles after the first accept with o_pc_d=0x0, o_pc_plus_4_d=0x4.
REQ-035 P_DEPTH=4, i_ready_d=0 -> exactly 4 requests issued, count=4, o_imem_req=0; one pop re-enables exactly one request.
REQ-036 3 requests outstanding, then redirect to 0x100 -> 3 responses dropped; the next buffered entry has o_pc_d=0x100 with the data from the 0x100 request.
REQ-037 Second redirect to 0x200 while drop_cnt=2 -> all stale responses dropped; the first delivered o_pc_d is 0x200.
REQ-038 pc_q=32'hFFFF_FFFC, request accepted -> next o_imem_addr=32'h0000_0000; that entry's o_pc_plus_4_d=0x0.
REQ-039 FETCH_MISALIGN_CHK_EN defined, redirect to 0x102 -> o_misalign=1, no requests issued; a following redirect to 0x104 clears it and fetch resumes at 0x104.
